// File: rtl/tilemap_pkg.sv
// Shared definitions for the tilemap index RAM arbiter: owner encoding and geometry.
package tilemap_pkg;

    localparam int TILEMAP_ADDR_W  = 10;
    localparam int TILEMAP_DATA_W  = 8;
    localparam int TILEMAP_CELLS_X = 22;
    localparam int TILEMAP_CELLS_Y = 17;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_VID  = 2'd1;
    localparam owner_t OWN_CPU  = 2'd2;
    localparam owner_t OWN_ENG  = 2'd3;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_VID = 0;
    localparam int GNT_CPU = 1;
    localparam int GNT_ENG = 2;

endpackage

// File: rtl/tilemapram_arb_pick.sv
// Combinational priority pick: video > CPU > engine, engine jumps the CPU when starved.
module tilemapram_arb_pick
    import tilemap_pkg::*;
(
    input  logic       vid_elig,
    input  logic       cpu_elig,
    input  logic       eng_elig,
    input  logic       starve_hit,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (vid_elig) begin
            grant[GNT_VID] = 1'b1;
        end else if (eng_elig && starve_hit) begin
            grant[GNT_ENG] = 1'b1;
        end else if (cpu_elig) begin
            grant[GNT_CPU] = 1'b1;
        end else if (eng_elig) begin
            grant[GNT_ENG] = 1'b1;
        end
    end

endmodule

// File: rtl/tilemapram_arbiter.sv
// Three-way arbiter for the single-port tilemap index RAM with one-cycle read latency.
// Optional wait statistics enabled by defining TILEMAPRAM_ARB_STATS_EN.
module tilemapram_arbiter
    import tilemap_pkg::*;
#(
    parameter int ADDR_W       = TILEMAP_ADDR_W,
    parameter int DATA_W       = TILEMAP_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_din,
    output logic              eng_ack,
    output logic [DATA_W-1:0] eng_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef TILEMAPRAM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [15:0]       stat_cpu_wait,
    output logic [15:0]       stat_eng_wait
`endif
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    owner_t            owner_p0;
    owner_t            owner_p1;
    logic [7:0]        starve_cnt;
    logic [ADDR_W-1:0] addr_hold_p1;
    logic [DATA_W-1:0] vid_dout_p1;
    logic [DATA_W-1:0] cpu_dout_p1;
    logic [DATA_W-1:0] eng_dout_p1;
    logic              vid_elig;
    logic              cpu_elig;
    logic              eng_elig;
    logic              starve_hit;
    logic [2:0]        grant;

    // The port being acked this cycle may not be granted again until next cycle
    assign vid_elig   = vid_req & ~reset;
    assign cpu_elig   = cpu_req & ~reset & (owner_p1 != OWN_CPU);
    assign eng_elig   = eng_req & ~reset & (owner_p1 != OWN_ENG);
    assign starve_hit = (starve_cnt == STARVE_MAX);

    tilemapram_arb_pick u_pick (
        .vid_elig   (vid_elig),
        .cpu_elig   (cpu_elig),
        .eng_elig   (eng_elig),
        .starve_hit (starve_hit),
        .grant      (grant)
    );

    // Stage p0: grant cycle, winner drives the RAM
    always_comb begin
        owner_p0 = OWN_NONE;
        ram_addr = addr_hold_p1;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (grant[GNT_VID]) begin
            owner_p0 = OWN_VID;
            ram_addr = vid_addr;
        end else if (grant[GNT_CPU]) begin
            owner_p0 = OWN_CPU;
            ram_addr = cpu_addr;
            ram_we   = cpu_we;
            ram_din  = cpu_din;
        end else if (grant[GNT_ENG]) begin
            owner_p0 = OWN_ENG;
            ram_addr = eng_addr;
            ram_we   = eng_we;
            ram_din  = eng_din;
        end
        if (reset) begin
            ram_addr = '0;
        end
    end

    // Stage p1: ack cycle, owner sees registered RAM data
    assign vid_valid = ~reset & (owner_p1 == OWN_VID);
    assign cpu_ack   = ~reset & (owner_p1 == OWN_CPU);
    assign eng_ack   = ~reset & (owner_p1 == OWN_ENG);

    assign vid_dout = reset ? '0 : (vid_valid ? ram_dout : vid_dout_p1);
    assign cpu_dout = reset ? '0 : (cpu_ack   ? ram_dout : cpu_dout_p1);
    assign eng_dout = reset ? '0 : (eng_ack   ? ram_dout : eng_dout_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_p1     <= OWN_NONE;
            starve_cnt   <= '0;
            addr_hold_p1 <= '0;
            vid_dout_p1  <= '0;
            cpu_dout_p1  <= '0;
            eng_dout_p1  <= '0;
        end else begin
            owner_p1    <= owner_p0;
            vid_dout_p1 <= vid_dout;
            cpu_dout_p1 <= cpu_dout;
            eng_dout_p1 <= eng_dout;
            if (|grant) begin
                addr_hold_p1 <= ram_addr;
            end
            if (!eng_req || grant[GNT_ENG]) begin
                starve_cnt <= '0;
            end else if (eng_elig && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

`ifdef TILEMAPRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            stat_cpu_wait <= '0;
            stat_eng_wait <= '0;
        end else begin
            if (cpu_elig && !grant[GNT_CPU] && (stat_cpu_wait != 16'hFFFF)) begin
                stat_cpu_wait <= stat_cpu_wait + 16'd1;
            end
            if (eng_elig && !grant[GNT_ENG] && (stat_eng_wait != 16'hFFFF)) begin
                stat_eng_wait <= stat_eng_wait + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tilemapram_arbiter.sv
// Bench for tilemapram_arbiter: vector table, directed corner sequences and a randomized run against a cycle model.
module tb_tilemapram_arbiter;
    import tilemap_pkg::*;

    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req, cpu_req, cpu_we, eng_req, eng_we;
    logic [AW-1:0] vid_addr, cpu_addr, eng_addr;
    logic [DW-1:0] cpu_din, eng_din;
    logic          vid_valid, cpu_ack, eng_ack;
    logic [DW-1:0] vid_dout, cpu_dout, eng_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef TILEMAPRAM_ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_cpu_wait, stat_eng_wait;
`endif

    always #5 clk = ~clk;

    tilemapram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_dout(vid_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_din(eng_din),
        .eng_ack(eng_ack), .eng_dout(eng_dout),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef TILEMAPRAM_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_cpu_wait(stat_cpu_wait), .stat_eng_wait(stat_eng_wait)
`endif
    );

    // Single-port RAM with registered read (old data on a write cycle)
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle();
        vid_req = 1'b0; cpu_req = 1'b0; eng_req = 1'b0; cpu_we = 1'b0; eng_we = 1'b0;
    endtask

    typedef struct {
        logic          v, c, e, cw, ew;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
        logic [2:0]    ack;  // {eng_ack, cpu_ack, vid_valid} in the following cycle
    } vec_t;
    vec_t tbl [10];

    // Cycle model state
    int            m_owner, m_starve, m_last;
    logic [DW-1:0] m_rd, e_vd, e_cd, e_ed;
    logic [DW-1:0] shadow [0:1023];

    initial begin
        reset = 1'b1;
        idle();
        vid_addr = '0; cpu_addr = '0; eng_addr = '0; cpu_din = '0; eng_din = '0;
`ifdef TILEMAPRAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[10'h025] = 8'h3C;

        // Reset state
        cyc(); cyc(); settle();
        check("rst_ram_addr", 32'(ram_addr), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_acks", 32'({eng_ack, cpu_ack, vid_valid}), 32'h0);
        cyc();
        reset = 1'b0;
        settle();
        check("post_rst_addr", 32'(ram_addr), 32'h0);
        check("post_rst_douts", 32'({vid_dout, cpu_dout, eng_dout}), 32'h0);
        cyc();

        // Vector table, each entry applied from an idle arbiter
        vid_addr = 10'h011; cpu_addr = 10'h022; cpu_din = 8'hA1; eng_addr = 10'h033; eng_din = 8'hB2;
        tbl[0] = '{1, 0, 0, 0, 0, 10'h011, 0, 8'h00, 3'b001};
        tbl[1] = '{0, 1, 0, 0, 0, 10'h022, 0, 8'h00, 3'b010};
        tbl[2] = '{0, 1, 0, 1, 0, 10'h022, 1, 8'hA1, 3'b010};
        tbl[3] = '{0, 0, 1, 0, 0, 10'h033, 0, 8'h00, 3'b100};
        tbl[4] = '{0, 0, 1, 0, 1, 10'h033, 1, 8'hB2, 3'b100};
        tbl[5] = '{1, 1, 0, 1, 0, 10'h011, 0, 8'h00, 3'b001};
        tbl[6] = '{1, 0, 1, 0, 1, 10'h011, 0, 8'h00, 3'b001};
        tbl[7] = '{0, 1, 1, 0, 0, 10'h022, 0, 8'h00, 3'b010};
        tbl[8] = '{1, 1, 1, 0, 0, 10'h011, 0, 8'h00, 3'b001};
        tbl[9] = '{0, 1, 1, 1, 1, 10'h022, 1, 8'hA1, 3'b010};
        for (int i = 0; i < 10; i++) begin
            vid_req = tbl[i].v; cpu_req = tbl[i].c; eng_req = tbl[i].e;
            cpu_we = tbl[i].cw; eng_we = tbl[i].ew;
            settle();
            check($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].a));
            check($sformatf("tbl%0d_we", i), 32'(ram_we), 32'(tbl[i].w));
            if (tbl[i].w) check($sformatf("tbl%0d_din", i), 32'(ram_din), 32'(tbl[i].d));
            cyc();
            idle();
            settle();
            check($sformatf("tbl%0d_ack", i), 32'({eng_ack, cpu_ack, vid_valid}), 32'(tbl[i].ack));
            cyc();
        end

        // Lone CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h025;
        settle();
        check("lone_addr", 32'(ram_addr), 32'h025);
        check("lone_ack_n", 32'(cpu_ack), 32'h0);
        cyc(); settle();
        check("lone_ack", 32'(cpu_ack), 32'h1);
        check("lone_dout", 32'(cpu_dout), 32'h3C);
        cyc();
        cpu_req = 1'b0;
        settle();
        check("lone_no_regrant", 32'(cpu_ack), 32'h0);
        check("lone_dout_hold", 32'(cpu_dout), 32'h3C);
        cyc();

        // Video preempts a CPU write for four cycles
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h0AA; cpu_din = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            vid_req = 1'b1; vid_addr = 10'(10'h100 + k);
            settle();
            check($sformatf("vp_we%0d", k), 32'(ram_we), 32'h0);
            check($sformatf("vp_addr%0d", k), 32'(ram_addr), 32'(10'h100 + k));
            if (k > 0) check($sformatf("vp_valid%0d", k), 32'(vid_valid), 32'h1);
            cyc();
        end
        vid_req = 1'b0;
        settle();
        check("vp_we4", 32'(ram_we), 32'h1);
        check("vp_addr4", 32'(ram_addr), 32'h0AA);
        check("vp_din4", 32'(ram_din), 32'h5A);
        check("vp_valid4", 32'(vid_valid), 32'h1);
        check("vp_cpuack4", 32'(cpu_ack), 32'h0);
        check("vp_viddout4", 32'(vid_dout), 32'(pat(10'h103)));
        cyc();
        cpu_req = 1'b0; cpu_we = 1'b0;
        settle();
        check("vp_cpuack5", 32'(cpu_ack), 32'h1);
        check("vp_valid5", 32'(vid_valid), 32'h0);
        cyc();
        check("vp_mem", 32'(mem[10'h0AA]), 32'h5A);

        // Starvation: video blocks four cycles, then the engine outranks the CPU
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0C0;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'h0E0;
        for (int k = 0; k < 4; k++) begin
            vid_req = 1'b1; vid_addr = 10'(10'h200 + k);
            settle();
            check($sformatf("sv_addr%0d", k), 32'(ram_addr), 32'(10'h200 + k));
            check($sformatf("sv_cnt%0d", k), 32'(dut.starve_cnt), 32'(k));
            cyc();
        end
        vid_req = 1'b0;
        settle();
        check("sv_eng_wins", 32'(ram_addr), 32'h0E0);
        check("sv_cnt4", 32'(dut.starve_cnt), 32'(LIM));
        cyc();
        eng_req = 1'b0;
        settle();
        check("sv_engack", 32'(eng_ack), 32'h1);
        check("sv_engdout", 32'(eng_dout), 32'(pat(10'h0E0)));
        check("sv_cpu_next", 32'(ram_addr), 32'h0C0);
        cyc();
        cpu_req = 1'b0;
        settle();
        check("sv_cnt_clr", 32'(dut.starve_cnt), 32'h0);
        check("sv_cpuack", 32'(cpu_ack), 32'h1);
        cyc();

        // CPU and engine together with no starvation
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h050;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'h060;
        settle();
        check("ce_cpu_first", 32'(ram_addr), 32'h050);
        cyc();
        cpu_req = 1'b0;
        settle();
        check("ce_cpuack", 32'({eng_ack, cpu_ack}), 32'b01);
        check("ce_cpudout", 32'(cpu_dout), 32'(pat(10'h050)));
        check("ce_eng_in_ack", 32'(ram_addr), 32'h060);
        cyc();
        eng_req = 1'b0;
        settle();
        check("ce_engack", 32'({eng_ack, cpu_ack}), 32'b10);
        check("ce_engdout", 32'(eng_dout), 32'(pat(10'h060)));
        cyc();

        // Reset in the cycle after a CPU read grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h025;
        settle();
        check("rm_grant", 32'(ram_addr), 32'h025);
        cyc();
        reset = 1'b1;
        settle();
        check("rm_ack_supp", 32'(cpu_ack), 32'h0);
        check("rm_ram", 32'({ram_we, ram_addr, ram_din}), 32'h0);
        check("rm_douts", 32'({vid_valid, eng_ack, vid_dout, cpu_dout, eng_dout}), 32'h0);
        cyc();
        reset = 1'b0;
        settle();
        check("rm_no_late_ack", 32'(cpu_ack), 32'h0);
        check("rm_regrant", 32'(ram_addr), 32'h025);
        cyc();
        cpu_req = 1'b0;
        settle();
        check("rm_ack", 32'(cpu_ack), 32'h1);
        check("rm_dout", 32'(cpu_dout), 32'h3C);
        cyc();

`ifdef TILEMAPRAM_ARB_STATS_EN
        // Engine denied for three eligible cycles by video
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'h070;
        for (int k = 0; k < 3; k++) begin
            vid_req = 1'b1; vid_addr = 10'(10'h300 + k);
            cyc();
        end
        vid_req = 1'b0;
        settle();
        check("st_grant", 32'(ram_addr), 32'h070);
        check("st_eng_wait", 32'(stat_eng_wait), 32'h3);
        cyc();
        eng_req = 1'b0;
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        settle();
        check("st_clr", 32'(stat_eng_wait), 32'h0);
        cyc();
`endif

        // Randomized run against the cycle model
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = pat(i + 11);
            shadow[i] = pat(i + 11);
        end
        m_owner = OWN_NONE; m_starve = 0; m_last = 0;
        m_rd = '0; e_vd = '0; e_cd = '0; e_ed = '0;
        for (int n = 0; n < 400; n++) begin
            int ce, ee, win, e_addr;
            logic e_we;
            logic [DW-1:0] e_din;
            vid_req  = ($urandom_range(0, 9) < 4);
            vid_addr = 10'($urandom_range(0, 1023));
            if (!cpu_req || m_owner == OWN_CPU) begin
                cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 10'($urandom_range(0, 15)); cpu_din = 8'($urandom);
            end
            if (!eng_req || m_owner == OWN_ENG) begin
                eng_req = 1'($urandom_range(0, 1)); eng_we = 1'($urandom_range(0, 1));
                eng_addr = 10'($urandom_range(0, 15)); eng_din = 8'($urandom);
            end
            settle();
            ce = (cpu_req && m_owner != OWN_CPU) ? 1 : 0;
            ee = (eng_req && m_owner != OWN_ENG) ? 1 : 0;
            if (vid_req) win = OWN_VID;
            else if (ee != 0 && (m_starve == LIM || ce == 0)) win = OWN_ENG;
            else if (ce != 0) win = OWN_CPU;
            else win = OWN_NONE;
            e_addr = m_last; e_we = 1'b0; e_din = '0;
            if (win == OWN_VID) e_addr = vid_addr;
            if (win == OWN_CPU) begin e_addr = cpu_addr; e_we = cpu_we; e_din = cpu_din; end
            if (win == OWN_ENG) begin e_addr = eng_addr; e_we = eng_we; e_din = eng_din; end
            if (m_owner == OWN_VID) e_vd = m_rd;
            if (m_owner == OWN_CPU) e_cd = m_rd;
            if (m_owner == OWN_ENG) e_ed = m_rd;
            check("rnd_ram_addr", 32'(ram_addr), 32'(e_addr));
            check("rnd_ram_we", 32'(ram_we), 32'(e_we));
            if (e_we) check("rnd_ram_din", 32'(ram_din), 32'(e_din));
            check("rnd_vid_valid", 32'(vid_valid), 32'(m_owner == OWN_VID));
            check("rnd_cpu_ack", 32'(cpu_ack), 32'(m_owner == OWN_CPU));
            check("rnd_eng_ack", 32'(eng_ack), 32'(m_owner == OWN_ENG));
            check("rnd_vid_dout", 32'(vid_dout), 32'(e_vd));
            check("rnd_cpu_dout", 32'(cpu_dout), 32'(e_cd));
            check("rnd_eng_dout", 32'(eng_dout), 32'(e_ed));
            if (win != OWN_NONE) begin
                m_rd = shadow[e_addr];
                if (e_we) shadow[e_addr] = e_din;
                m_last = e_addr;
            end
            if (!eng_req || win == OWN_ENG) m_starve = 0;
            else if (ee != 0 && m_starve < LIM) m_starve++;
            m_owner = win;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
